// File: rtl/vector_ram_pkg.sv
// Shared types for the vector RAM configuration path: loader FSM states and
// default geometry used as parameter defaults by the loader and packer.
package vector_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cfg_ld_state_t;

  localparam int VEC_LENGTH_DEF      = 32;
  localparam int VEC_DATA_WIDTH_DEF  = 32;
  localparam int VEC_PARALLELISM_DEF = 4;

endpackage

// File: rtl/vector_pack.sv
// Scalar-to-vector packer: collects PARALLELISM words into a lane register and
// presents the completed vector, including a same-cycle bypass of the last lane.
module vector_pack
  import vector_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = VEC_DATA_WIDTH_DEF,
  parameter int PARALLELISM = VEC_PARALLELISM_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              pop,
  output logic                              full,
  output logic                              vec_valid,
  output logic [PARALLELISM*DATA_WIDTH-1:0] vec_data
);

  localparam int LW = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
  typedef logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data_vec_t;

  data_vec_t     data_q, data_d, merged;
  logic [LW-1:0] lane_q, lane_d;
  logic          full_q, full_d;
  logic          last_lane;

  always_comb begin
    last_lane = (lane_q == LW'(PARALLELISM - 1));
    merged    = data_q;
    if (push) merged[lane_q] = push_data;
    data_d = merged;
    lane_d = lane_q;
    full_d = full_q;
    if (push) lane_d = last_lane ? '0 : lane_q + 1'b1;
    // A pop in the cycle the last lane arrives consumes the bypassed vector,
    // so the full flag only latches when the vector could not leave.
    if (pop)                    full_d = 1'b0;
    else if (push && last_lane) full_d = 1'b1;
    if (clr) begin
      lane_d = '0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      lane_q <= lane_d;
      full_q <= full_d;
    end
  end

  assign full      = full_q;
  assign vec_valid = full_q || (push && last_lane);
  assign vec_data  = merged;

endmodule

// File: rtl/vector_cfg_loader.sv
// Loads a vector bank through the cfg port: packs scalar words into beats,
// generates lane addresses, holds cfg_en during a load and owns the ping select.
module vector_cfg_loader
  import vector_ram_pkg::*;
#(
  parameter int LENGTH      = VEC_LENGTH_DEF,
  parameter int DATA_WIDTH  = VEC_DATA_WIDTH_DEF,
  parameter int PARALLELISM = VEC_PARALLELISM_DEF,
  localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              swap,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              cfg_valid,
  input  logic                              cfg_ready,
  output logic                              cfg_write,
  output logic [PARALLELISM*ADDR_WIDTH-1:0] cfg_addr,
  output logic [PARALLELISM*DATA_WIDTH-1:0] cfg_wdata,
  output logic                              cfg_en,
  output logic                              ping,
  output logic                              busy,
  output logic                              done
);

  localparam int BEATS = LENGTH / PARALLELISM;
  localparam int BW    = $clog2(BEATS + 1);
  typedef logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr_vec_t;
  typedef logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data_vec_t;

  cfg_ld_state_t         state_q, state_d;
  logic                  ping_q, ping_d;
  logic                  out_valid_q, out_valid_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  addr_vec_t             addr_q, addr_d;
  data_vec_t             wdata_q, wdata_d;

  logic active, accept, handshake, transfer, pack_clr, pack_full, vec_valid;
  logic [PARALLELISM*DATA_WIDTH-1:0] vec_data;

  // Both ports use valid/ready: a transfer happens on a cycle where valid and
  // ready are both high; once raised, valid and its payload hold until then.
  assign active    = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign in_ready  = (state_q == ST_LOAD) && !pack_full;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && cfg_ready;
  assign transfer  = active && !abort && vec_valid && (!out_valid_q || cfg_ready);

  vector_pack #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARALLELISM(PARALLELISM)
  ) u_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (pack_clr),
    .push     (accept),
    .push_data(in_data),
    .pop      (transfer),
    .full     (pack_full),
    .vec_valid(vec_valid),
    .vec_data (vec_data)
  );

  always_comb begin
    state_d     = state_q;
    ping_d      = ping_q;
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    base_d      = base_q;
    word_d      = word_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pack_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          beat_d   = '0;
          base_d   = '0;
          word_d   = '0;
          pack_clr = 1'b1;
        end else if (swap) begin
          ping_d = !ping_q;
        end
      end
      ST_LOAD, ST_DRAIN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          beat_d      = '0;
          base_d      = '0;
          word_d      = '0;
          pack_clr    = 1'b1;
        end else begin
          if (handshake) begin
            out_valid_d = 1'b0;
            beat_d      = beat_q + 1'b1;
            if (beat_q == BW'(BEATS - 1)) state_d = ST_DONE;
          end
          if (transfer) begin
            out_valid_d = 1'b1;
            wdata_d     = vec_data;
            for (int i = 0; i < PARALLELISM; i++) addr_d[i] = base_q + ADDR_WIDTH'(i);
            base_d = base_q + ADDR_WIDTH'(PARALLELISM);
          end
          if (accept) begin
            word_d = word_q + 1'b1;
            if (word_q == ADDR_WIDTH'(LENGTH - 1)) state_d = ST_DRAIN;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ping_q      <= 1'b0;
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      base_q      <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ping_q      <= ping_d;
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cfg_valid = out_valid_q;
  assign cfg_write = out_valid_q;
  assign cfg_addr  = addr_q;
  assign cfg_wdata = wdata_q;
  assign cfg_en    = active;
  assign ping      = ping_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_vector_cfg_loader.sv
// Directed bench for vector_cfg_loader (LENGTH=32, PARALLELISM=4): full-rate,
// stalled, gappy, swap, abort and asynchronous reset scenarios.
module tb_vector_cfg_loader;

  localparam int LEN   = 32;
  localparam int DW    = 32;
  localparam int P     = 4;
  localparam int AW    = 5;
  localparam int BEATS = LEN / P;

  logic            clk, rst, start, abort, swap;
  logic            in_valid, in_ready, cfg_valid, cfg_ready, cfg_write;
  logic [DW-1:0]   in_data;
  logic [P*AW-1:0] cfg_addr;
  logic [P*DW-1:0] cfg_wdata;
  logic            cfg_en, ping, busy, done;

  logic [DW-1:0] exp_q[$];
  int vec_cnt = 0;
  int miscompares = 0;

  vector_cfg_loader #(.LENGTH(LEN), .DATA_WIDTH(DW), .PARALLELISM(P)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .swap(swap),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_en(cfg_en),
    .ping(ping), .busy(busy), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One complete load. mode 0: full rate, 1: cfg_ready stall while beat 1 is
  // presented, 2: random in_valid gaps. swap_at / abort_at pulse on that offset.
  task automatic run_load(input logic [DW-1:0] dbase, input int mode, input int swap_at,
                          input bit swap_with_start, input int abort_at);
    int widx = 0, beat = 0, done_cnt = 0, done_off = -1, stall_acc = 0, first_hs = -1;
    logic ping_before;
    logic [P*DW-1:0] exp_data;
    logic [P*AW-1:0] exp_addr;
    bit in_stall;
    exp_q.delete();
    for (int i = 0; i < LEN; i++) exp_q.push_back(dbase + DW'(i));
    ping_before = ping;
    start = 1'b1; swap = swap_with_start; in_valid = 1'b0; cfg_ready = 1'b1; abort = 1'b0;
    tick();
    start = 1'b0;
    for (int off = 1; off <= 200; off++) begin
      in_stall  = (mode == 1) && (off >= 9) && (off <= 18);
      in_valid  = (widx < LEN) && ((mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data   = dbase + DW'(widx);
      cfg_ready = !in_stall;
      swap      = (off == swap_at);
      abort     = (off == abort_at);
      #1;
      if (off == 1) begin
        check_vec("busy_t1", busy, 1);
        check_vec("cfg_en_t1", cfg_en, 1);
        check_vec("in_ready_t1", in_ready, 1);
      end
      if (in_stall) begin
        for (int i = 0; i < P; i++) begin
          exp_data[i*DW +: DW] = exp_q[i];
          exp_addr[i*AW +: AW] = AW'(beat * P + i);
        end
        check_vec("stall_valid", cfg_valid, 1);
        check_vec("stall_wdata", cfg_wdata, exp_data);
        check_vec("stall_addr", cfg_addr, exp_addr);
      end
      if (off == abort_at) check_vec("abort_has_valid", cfg_valid, 1);
      if (abort_at > 0 && off == abort_at + 1) begin
        check_vec("abort_valid_low", cfg_valid, 0);
        check_vec("abort_busy_low", busy, 0);
      end
      if (in_valid && in_ready) begin
        widx++;
        if (in_stall) stall_acc++;
      end
      if (cfg_valid && cfg_ready) begin
        if (first_hs < 0) first_hs = off;
        if (beat >= BEATS || exp_q.size() < P) begin
          check_vec("extra_beat", 1, 0);
        end else begin
          for (int i = 0; i < P; i++) begin
            exp_data[i*DW +: DW] = exp_q.pop_front();
            exp_addr[i*AW +: AW] = AW'(beat * P + i);
          end
          check_vec($sformatf("beat%0d_wdata", beat), cfg_wdata, exp_data);
          check_vec($sformatf("beat%0d_addr", beat), cfg_addr, exp_addr);
          check_vec("cfg_write", cfg_write, 1);
        end
        beat++;
      end
      if (done) begin
        done_cnt++;
        done_off = off;
        check_vec("cfg_en_at_done", cfg_en, 0);
      end
      tick();
      if (done_off >= 0) break;
      if (abort_at > 0 && off >= abort_at + 2) break;
    end
    swap = 1'b0; abort = 1'b0; in_valid = 1'b0; cfg_ready = 1'b1;
    #1;
    check_vec("ping_kept", ping, ping_before);
    if (abort_at > 0) begin
      check_vec("abort_no_done", done_cnt, 0);
    end else begin
      check_vec("done_count", done_cnt, 1);
      check_vec("beat_count", beat, BEATS);
      check_vec("words_left", exp_q.size(), 0);
      check_vec("idle_after_done", busy, 0);
      if (mode == 0) begin
        check_vec("done_latency", done_off, LEN + 2);
        check_vec("first_beat_off", first_hs, 5);
      end
      if (mode == 1) check_vec("stall_words", stall_acc, 4);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; swap = 1'b0;
    in_valid = 1'b0; in_data = '0; cfg_ready = 1'b0;
    tick(); tick();
    #1;
    check_vec("rst_in_ready", in_ready, 0);
    check_vec("rst_cfg_valid", cfg_valid, 0);
    check_vec("rst_cfg_addr", cfg_addr, 0);
    check_vec("rst_cfg_wdata", cfg_wdata, 0);
    check_vec("rst_ping", ping, 0);
    check_vec("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    #1;
    check_vec("idle_cfg_en", cfg_en, 0);
    check_vec("idle_done", done, 0);

    // swap in IDLE toggles ping on the next cycle
    swap = 1'b1;
    tick();
    swap = 1'b0;
    #1;
    check_vec("swap_idle", ping, 1);

    run_load(32'h0000_0000, 0, -1, 1'b0, -1);
    run_load(32'h0000_1000, 1, -1, 1'b0, -1);
    run_load(32'h0000_2000, 2, 3, 1'b0, -1);
    run_load(32'h0000_3000, 0, -1, 1'b1, -1);
    run_load(32'h0000_4000, 0, -1, 1'b0, LEN + 1);
    run_load(32'h0000_5000, 0, -1, 1'b0, -1);

    // asynchronous reset in the middle of a load with a beat held on cfg
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 32'hdead_0001; cfg_ready = 1'b0;
    repeat (10) tick();
    #1;
    check_vec("pre_rst_valid", cfg_valid, 1);
    #1 rst = 1'b1;
    #1;
    check_vec("arst_in_ready", in_ready, 0);
    check_vec("arst_cfg_valid", cfg_valid, 0);
    check_vec("arst_cfg_write", cfg_write, 0);
    check_vec("arst_cfg_addr", cfg_addr, 0);
    check_vec("arst_cfg_wdata", cfg_wdata, 0);
    check_vec("arst_cfg_en", cfg_en, 0);
    check_vec("arst_ping", ping, 0);
    check_vec("arst_busy", busy, 0);
    check_vec("arst_done", done, 0);
    #1 rst = 1'b0;
    in_valid = 1'b0; cfg_ready = 1'b1;
    tick();
    #1;
    check_vec("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
